// File: rtl/free_list_pkg.sv
// Shared defaults and width helpers for the rename-stage physical-register free list.
package free_list_pkg;

  localparam int DEFAULT_DEPTH     = 32;
  localparam int DEFAULT_NUM_PORTS = 3;
  localparam int DEFAULT_TAG_W     = 6;
  localparam int DEFAULT_INIT_BASE = 32;
  localparam int DEFAULT_NUM_CKPT  = 4;

  // Pointer width carries one wrap bit above the index so full and empty differ.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ckpt_id_width(input int num_ckpt);
    return (num_ckpt > 1) ? $clog2(num_ckpt) : 1;
  endfunction

endpackage

// File: rtl/free_list_np_prefix_count.sv
// Exclusive prefix popcount: rank[i] counts set bits strictly below bit i.
module prefix_count #(
  parameter int N  = 3,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         bits,
  output logic [N-1:0][CW-1:0] rank,
  output logic [CW-1:0]        total
);

  logic [CW-1:0] acc;

  always_comb begin
    acc  = '0;
    rank = '0;
    for (int i = 0; i < N; i++) begin
      rank[i] = acc;
      acc     = acc + CW'(bits[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/free_list_np.sv
// Circular-buffer free list with compacted alloc/free ports and rd_ptr checkpoints
// for single-cycle misprediction recovery.
module free_list_np
  import free_list_pkg::*;
#(
  parameter  int DEPTH     = DEFAULT_DEPTH,
  parameter  int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter  int TAG_W     = DEFAULT_TAG_W,
  parameter  int INIT_BASE = DEFAULT_INIT_BASE,
  parameter  int NUM_CKPT  = DEFAULT_NUM_CKPT,
  localparam int PW        = ptr_width(DEPTH),
  localparam int CKW       = ckpt_id_width(NUM_CKPT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            alloc_req,
  output logic [NUM_PORTS-1:0][TAG_W-1:0] alloc_tag,
  output logic [NUM_PORTS-1:0]            alloc_valid,
  input  logic [NUM_PORTS-1:0]            free_en,
  input  logic [NUM_PORTS-1:0][TAG_W-1:0] free_tag,
  input  logic                            ckpt_save,
  input  logic [CKW-1:0]                  ckpt_save_id,
  input  logic                            ckpt_restore,
  input  logic [CKW-1:0]                  ckpt_restore_id,
  output logic [PW-1:0]                   count,
  output logic                            empty,
  output logic                            full,
  output logic                            overflow_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_PORTS + 1);

  logic [TAG_W-1:0] mem  [DEPTH];
  logic [PW-1:0]    ckpt [NUM_CKPT];
  logic [PW-1:0]    rd_ptr, wr_ptr;

  logic [NUM_PORTS-1:0][CW-1:0] a_rank, f_rank;
  logic [CW-1:0]                a_total, f_total;

  prefix_count #(.N(NUM_PORTS), .CW(CW)) u_alloc_rank (
    .bits  (alloc_req),
    .rank  (a_rank),
    .total (a_total)
  );

  prefix_count #(.N(NUM_PORTS), .CW(CW)) u_free_rank (
    .bits  (free_en),
    .rank  (f_rank),
    .total (f_total)
  );

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == PW'(DEPTH));

  // alloc_valid[i] is a grant, not a request for acknowledgement: whenever it is
  // high at the rising edge the tag on alloc_tag[i] is consumed; there is no ready.
  logic [PW-1:0] n_grant;
  logic [IW-1:0] ridx;

  always_comb begin
    alloc_valid = '0;
    alloc_tag   = '0;
    n_grant     = '0;
    ridx        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (alloc_req[i] && !ckpt_restore && (PW'(a_rank[i]) < count)) begin
        ridx           = rd_ptr[IW-1:0] + IW'(a_rank[i]);
        alloc_valid[i] = 1'b1;
        alloc_tag[i]   = mem[ridx];
        n_grant        = n_grant + PW'(1);
      end
    end
  end

  // Free acceptance is judged against the registered count; same-cycle grants do
  // not make extra room.
  logic [NUM_PORTS-1:0]         free_ok;
  logic [NUM_PORTS-1:0][IW-1:0] widx;
  logic [PW-1:0]                n_free;
  logic                         free_drop;

  always_comb begin
    free_ok   = '0;
    widx      = '0;
    n_free    = '0;
    free_drop = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      widx[i] = wr_ptr[IW-1:0] + IW'(f_rank[i]);
      if (free_en[i]) begin
        if (int'(count) + int'(f_rank[i]) < DEPTH) begin
          free_ok[i] = 1'b1;
          n_free     = n_free + PW'(1);
        end else begin
          free_drop = 1'b1;
        end
      end
    end
  end

  logic [PW-1:0] rd_post_alloc, wr_next, rd_next, restore_val, restored_count;
  logic          restore_ovf;

  always_comb begin
    rd_post_alloc  = rd_ptr + n_grant;
    wr_next        = wr_ptr + n_free;
    restore_val    = ckpt[ckpt_restore_id];
    restored_count = wr_next - restore_val;
    restore_ovf    = ckpt_restore && (int'(restored_count) > DEPTH);
    rd_next        = rd_post_alloc;
    if (ckpt_restore) begin
      rd_next = restore_ovf ? (wr_next - PW'(DEPTH)) : restore_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= PW'(DEPTH);
      overflow_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= TAG_W'(INIT_BASE + i);
      end
      for (int c = 0; c < NUM_CKPT; c++) begin
        ckpt[c] <= '0;
      end
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_next;
      if (free_drop || restore_ovf) begin
        overflow_err <= 1'b1;
      end
      if (ckpt_save && !ckpt_restore) begin
        ckpt[ckpt_save_id] <= rd_post_alloc;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (free_ok[i]) begin
          mem[widx[i]] <= free_tag[i];
        end
      end
    end
  end

endmodule
